// File: rtl/sd_spi_path_sched.sv
// Routes the core's single SPI master to either the virtual or the physical SD card,
// switching only after the bus has been idle long enough that no transaction is split.
module sd_spi_path_sched #(
   parameter int unsigned IDLE_CYCLES = 16,
   parameter int unsigned ACT_TIMEOUT = 1000000,
   parameter int unsigned RST_PULSE   = 32
) (
   input  logic clk_sys,
   input  logic reset,
   input  logic img_mounted,
   input  logic img_size_nz,
   input  logic reset_on_mount,
   input  logic spi_sck,
   input  logic spi_mosi,
   input  logic spi_ss,
   output logic spi_miso,
   output logic vsd_ss,
   input  logic vsd_miso,
   output logic sd_cs,
   output logic sd_sck,
   output logic sd_mosi,
   input  logic sd_miso,
   output logic vsd_sel,
   output logic led_vsd,
   output logic led_phys,
   output logic mount_reset
);

   localparam int unsigned IdleW = $clog2(IDLE_CYCLES + 1);
   localparam int unsigned ActW  = $clog2(ACT_TIMEOUT + 1);
   localparam int unsigned RstW  = $clog2(RST_PULSE + 1);

   typedef enum logic [0:0] {StSteady, StDrain} state_e;

   state_e           state_q, state_d;
   logic             sel_q, sel_d;
   logic             tgt_q, tgt_d;
   logic             rst_req_q, rst_req_d;
   logic [IdleW-1:0] idle_cnt_q, idle_cnt_d;
   logic [ActW-1:0]  act_cnt_q, act_cnt_d;
   logic [RstW-1:0]  rst_cnt_q, rst_cnt_d;
   logic             mosi_q, miso_q;
   logic             commit;
   logic             toggle;

   // A mount strobe always wins over a commit in the same cycle.
   always_comb begin
      state_d    = state_q;
      sel_d      = sel_q;
      tgt_d      = tgt_q;
      rst_req_d  = rst_req_q;
      idle_cnt_d = idle_cnt_q;
      commit     = 1'b0;
      if (img_mounted) begin
         tgt_d      = img_size_nz;
         rst_req_d  = reset_on_mount;
         idle_cnt_d = '0;
         state_d    = StDrain;
      end else if (state_q == StDrain) begin
         if (!spi_ss) begin
            idle_cnt_d = '0;
         end else if (idle_cnt_q == IdleW'(IDLE_CYCLES - 1)) begin
            commit  = 1'b1;
            sel_d   = tgt_q;
            state_d = StSteady;
         end else begin
            idle_cnt_d = idle_cnt_q + IdleW'(1);
         end
      end
   end

   always_comb begin
      rst_cnt_d = rst_cnt_q;
      if (commit && rst_req_q) begin
         rst_cnt_d = RstW'(RST_PULSE);
      end else if (rst_cnt_q != '0) begin
         rst_cnt_d = rst_cnt_q - RstW'(1);
      end
   end

   assign toggle = (spi_mosi ^ mosi_q) | (spi_miso ^ miso_q);

   always_comb begin
      act_cnt_d = act_cnt_q;
      if (toggle) begin
         act_cnt_d = ActW'(ACT_TIMEOUT);
      end else if (act_cnt_q != '0) begin
         act_cnt_d = act_cnt_q - ActW'(1);
      end
   end

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         state_q    <= StSteady;
         sel_q      <= 1'b0;
         tgt_q      <= 1'b0;
         rst_req_q  <= 1'b0;
         idle_cnt_q <= '0;
         act_cnt_q  <= '0;
         rst_cnt_q  <= '0;
         mosi_q     <= 1'b0;
         miso_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         sel_q      <= sel_d;
         tgt_q      <= tgt_d;
         rst_req_q  <= rst_req_d;
         idle_cnt_q <= idle_cnt_d;
         act_cnt_q  <= act_cnt_d;
         rst_cnt_q  <= rst_cnt_d;
         mosi_q     <= spi_mosi;
         miso_q     <= spi_miso;
      end
   end

   assign sd_cs       = spi_ss | sel_q;
   assign sd_sck      = spi_sck & ~sel_q;
   assign sd_mosi     = spi_mosi & ~sel_q;
   assign vsd_ss      = spi_ss | ~sel_q;
   assign spi_miso    = sel_q ? vsd_miso : sd_miso;
   assign vsd_sel     = sel_q;
   assign led_vsd     = (act_cnt_q != '0) & sel_q;
   assign led_phys    = (act_cnt_q != '0) & ~sel_q;
   assign mount_reset = (rst_cnt_q != '0);

endmodule

// File: tb/tb_sd_spi_path_sched.sv
// Directed bench for sd_spi_path_sched: commit latency, idle restarts, mount pulse,
// activity stretch and asynchronous reset.
module tb_sd_spi_path_sched;

   logic clk_sys = 1'b0;
   logic reset, img_mounted, img_size_nz, reset_on_mount;
   logic spi_sck, spi_mosi, spi_ss, spi_miso;
   logic vsd_ss, vsd_miso, sd_cs, sd_sck, sd_mosi, sd_miso;
   logic vsd_sel, led_vsd, led_phys, mount_reset;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk_sys = ~clk_sys;

   sd_spi_path_sched #(
      .IDLE_CYCLES(16),
      .ACT_TIMEOUT(100),
      .RST_PULSE  (32)
   ) dut (
      .clk_sys       (clk_sys),
      .reset         (reset),
      .img_mounted   (img_mounted),
      .img_size_nz   (img_size_nz),
      .reset_on_mount(reset_on_mount),
      .spi_sck       (spi_sck),
      .spi_mosi      (spi_mosi),
      .spi_ss        (spi_ss),
      .spi_miso      (spi_miso),
      .vsd_ss        (vsd_ss),
      .vsd_miso      (vsd_miso),
      .sd_cs         (sd_cs),
      .sd_sck        (sd_sck),
      .sd_mosi       (sd_mosi),
      .sd_miso       (sd_miso),
      .vsd_sel       (vsd_sel),
      .led_vsd       (led_vsd),
      .led_phys      (led_phys),
      .mount_reset   (mount_reset)
   );

   task automatic step();
      @(negedge clk_sys);
   endtask

   // Strobe lands on the next rising edge T; returns at the falling edge after T.
   task automatic mount(input logic nz, input logic rom);
      img_mounted    = 1'b1;
      img_size_nz    = nz;
      reset_on_mount = rom;
      step();
      img_mounted    = 1'b0;
   endtask

   task automatic test_reset();
      spi_ss = 1'b1; spi_sck = 1'b1;
      #1 reset = 1'b1;
      #1;
      n_checks++; if (vsd_sel !== 1'b0) $display("FAIL reset_vsd_sel: got %b want 0", vsd_sel); else n_pass++;
      n_checks++; if (mount_reset !== 1'b0) $display("FAIL reset_mount_reset: got %b want 0", mount_reset); else n_pass++;
      n_checks++; if ({led_vsd, led_phys} !== 2'b00) $display("FAIL reset_leds: got %b want 00", {led_vsd, led_phys}); else n_pass++;
      n_checks++; if ({vsd_ss, sd_cs, sd_sck} !== 3'b111) $display("FAIL reset_route_hi: got %b want 111", {vsd_ss, sd_cs, sd_sck}); else n_pass++;
      spi_ss = 1'b0; spi_sck = 1'b0;
      #1;
      n_checks++; if ({vsd_ss, sd_cs, sd_sck} !== 3'b100) $display("FAIL reset_route_lo: got %b want 100", {vsd_ss, sd_cs, sd_sck}); else n_pass++;
      step(); step();
      spi_ss = 1'b1;
      reset  = 1'b0;
      step();
   endtask

   task automatic test_basic_commit();
      logic early;
      early = 1'b0;
      mount(1'b1, 1'b0);
      for (int p = 1; p <= 15; p++) begin
         step();
         if (vsd_sel !== 1'b0 || mount_reset !== 1'b0) early = 1'b1;
      end
      n_checks++; if (early) $display("FAIL basic_early: vsd_sel/mount_reset changed before edge T+16"); else n_pass++;
      step();
      n_checks++; if (vsd_sel !== 1'b1) $display("FAIL basic_commit: got %b want 1", vsd_sel); else n_pass++;
      n_checks++; if (mount_reset !== 1'b0) $display("FAIL basic_no_pulse: got %b want 0", mount_reset); else n_pass++;
      spi_ss = 1'b0; vsd_miso = 1'b1;
      #1;
      n_checks++; if ({sd_cs, vsd_ss, spi_miso} !== 3'b101) $display("FAIL basic_route_virt: got %b want 101", {sd_cs, vsd_ss, spi_miso}); else n_pass++;
      step();
      spi_ss = 1'b1; vsd_miso = 1'b0;
      #1;
      n_checks++; if ({sd_cs, vsd_ss} !== 2'b11) $display("FAIL basic_ss_idle: got %b want 11", {sd_cs, vsd_ss}); else n_pass++;
      step();
   endtask

   task automatic test_ss_hold();
      spi_ss = 1'b0;
      mount(1'b0, 1'b0);
      for (int i = 0; i < 40; i++) step();
      n_checks++; if (vsd_sel !== 1'b1) $display("FAIL hold_busy: got %b want 1", vsd_sel); else n_pass++;
      spi_ss = 1'b1;
      for (int i = 0; i < 15; i++) step();
      n_checks++; if (vsd_sel !== 1'b1) $display("FAIL hold_before: got %b want 1", vsd_sel); else n_pass++;
      step();
      n_checks++; if (vsd_sel !== 1'b0) $display("FAIL hold_commit: got %b want 0", vsd_sel); else n_pass++;
   endtask

   task automatic test_mount_pulse();
      int cnt;
      mount(1'b1, 1'b1);
      for (int p = 1; p <= 15; p++) step();
      n_checks++; if ({vsd_sel, mount_reset} !== 2'b00) $display("FAIL pulse_pre: got %b want 00", {vsd_sel, mount_reset}); else n_pass++;
      step();
      n_checks++; if ({vsd_sel, mount_reset} !== 2'b11) $display("FAIL pulse_start: got %b want 11", {vsd_sel, mount_reset}); else n_pass++;
      cnt = 0;
      for (int i = 0; i < 100 && mount_reset; i++) begin cnt++; step(); end
      n_checks++; if (cnt != 32) $display("FAIL pulse_width: got %0d want 32", cnt); else n_pass++;
   endtask

   task automatic test_same_target();
      logic changed;
      int cnt;
      changed = 1'b0;
      mount(1'b1, 1'b1);
      for (int p = 1; p <= 15; p++) begin
         step();
         if (vsd_sel !== 1'b1 || mount_reset !== 1'b0) changed = 1'b1;
      end
      step();
      if (vsd_sel !== 1'b1) changed = 1'b1;
      n_checks++; if (changed) $display("FAIL same_stable: vsd_sel moved or pulse came early"); else n_pass++;
      n_checks++; if (mount_reset !== 1'b1) $display("FAIL same_pulse: got %b want 1", mount_reset); else n_pass++;
      cnt = 0;
      for (int i = 0; i < 100 && mount_reset; i++) begin cnt++; step(); end
      n_checks++; if (cnt != 32) $display("FAIL same_width: got %0d want 32", cnt); else n_pass++;
   endtask

   task automatic test_glitch();
      mount(1'b0, 1'b0);
      for (int p = 1; p <= 10; p++) step();
      spi_ss = 1'b0;
      step();
      spi_ss = 1'b1;
      for (int p = 12; p <= 16; p++) step();
      n_checks++; if (vsd_sel !== 1'b1) $display("FAIL glitch_no_early: got %b want 1", vsd_sel); else n_pass++;
      for (int p = 17; p <= 26; p++) step();
      n_checks++; if (vsd_sel !== 1'b1) $display("FAIL glitch_before: got %b want 1", vsd_sel); else n_pass++;
      step();
      n_checks++; if (vsd_sel !== 1'b0) $display("FAIL glitch_commit: got %b want 0", vsd_sel); else n_pass++;
   endtask

   task automatic test_back_to_back();
      logic toggled, early;
      toggled = 1'b0; early = 1'b0;
      mount(1'b1, 1'b0);
      for (int i = 0; i < 4; i++) step();
      mount(1'b0, 1'b1);
      for (int p = 1; p <= 15; p++) begin
         step();
         if (vsd_sel !== 1'b0) toggled = 1'b1;
         if (mount_reset !== 1'b0) early = 1'b1;
      end
      step();
      n_checks++; if (early) $display("FAIL b2b_early_pulse: mount_reset before second commit"); else n_pass++;
      n_checks++; if (mount_reset !== 1'b1) $display("FAIL b2b_pulse: got %b want 1", mount_reset); else n_pass++;
      for (int i = 0; i < 40; i++) begin
         if (vsd_sel !== 1'b0) toggled = 1'b1;
         step();
      end
      n_checks++; if (toggled) $display("FAIL b2b_sel: vsd_sel toggled, want steady 0"); else n_pass++;
      n_checks++; if (mount_reset !== 1'b0) $display("FAIL b2b_pulse_end: got %b want 0", mount_reset); else n_pass++;
   endtask

   task automatic test_activity();
      int cnt;
      logic phys_on;
      mount(1'b1, 1'b0);
      for (int i = 0; i < 130; i++) step();
      n_checks++; if ({vsd_sel, led_vsd, led_phys} !== 3'b100) $display("FAIL act_idle: got %b want 100", {vsd_sel, led_vsd, led_phys}); else n_pass++;
      spi_mosi = 1'b1;
      step();
      cnt = 0; phys_on = 1'b0;
      for (int i = 0; i < 400 && led_vsd; i++) begin
         cnt++;
         if (led_phys) phys_on = 1'b1;
         step();
      end
      n_checks++; if (cnt != 100) $display("FAIL act_single: got %0d want 100", cnt); else n_pass++;
      n_checks++; if (phys_on) $display("FAIL act_phys_led: led_phys rose with sel=1"); else n_pass++;
      spi_mosi = 1'b0;
      step();
      cnt = 0;
      for (int i = 0; i < 400 && led_vsd; i++) begin
         cnt++;
         if (cnt == 50) vsd_miso = ~vsd_miso;
         step();
      end
      n_checks++; if (cnt != 150) $display("FAIL act_extend: got %0d want 150", cnt); else n_pass++;
   endtask

   task automatic test_async_reset();
      mount(1'b1, 1'b1);
      for (int p = 1; p <= 16; p++) step();
      for (int i = 0; i < 5; i++) step();
      mount(1'b0, 1'b0);
      for (int i = 0; i < 3; i++) step();
      n_checks++; if ({vsd_sel, mount_reset} !== 2'b11) $display("FAIL areset_pre: got %b want 11", {vsd_sel, mount_reset}); else n_pass++;
      #2 reset = 1'b1;
      spi_ss = 1'b0;
      #1;
      n_checks++; if ({vsd_sel, mount_reset, led_vsd, led_phys} !== 4'b0000) $display("FAIL areset_outs: got %b want 0000", {vsd_sel, mount_reset, led_vsd, led_phys}); else n_pass++;
      n_checks++; if ({vsd_ss, sd_cs} !== 2'b10) $display("FAIL areset_route: got %b want 10", {vsd_ss, sd_cs}); else n_pass++;
      step();
      spi_ss = 1'b1;
      reset  = 1'b0;
      // Pending virtual switch must be dropped by reset.
      step();
      mount(1'b1, 1'b0);
      for (int i = 0; i < 5; i++) step();
      #2 reset = 1'b1;
      step();
      reset = 1'b0;
      for (int i = 0; i < 40; i++) step();
      n_checks++; if ({vsd_sel, mount_reset} !== 2'b00) $display("FAIL areset_discard: got %b want 00", {vsd_sel, mount_reset}); else n_pass++;
   endtask

   initial begin
      reset = 1'b0; img_mounted = 1'b0; img_size_nz = 1'b0; reset_on_mount = 1'b0;
      spi_sck = 1'b0; spi_mosi = 1'b0; spi_ss = 1'b1; vsd_miso = 1'b0; sd_miso = 1'b0;
      test_reset();
      test_basic_commit();
      test_ss_hold();
      test_mount_pulse();
      test_same_target();
      test_glitch();
      test_back_to_back();
      test_activity();
      test_async_reset();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
